ro_puf_meas_ctrl: RTL and testbench

//   Measurement controller and reader for the ring-oscillator PUF counter pair.
//   - Accepts a challenge naming two ROs: RO A and RO B.
//   - Clears both edge counters, then enables the ROs for a fixed window.
//   - Reads both counts and returns one response bit over a valid/ready handshake.
//   - Sits between the challenge source (UART/host FSM) and the RO mux + counter datapath.

---
 rtl/puf_pkg.sv | 17 +
 rtl/puf_window_timer.sv | 28 ++
 rtl/ro_puf_meas_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ro_puf_meas_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and defaults for the RO PUF measurement controller.
// Holds the FSM state encoding and the default datapath widths.
package puf_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int SEL_W_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_CMP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/puf_window_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// One instance times the CLR, RUN and SETTLE phases in turn.
module puf_window_timer #(
  parameter int TW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  // Load on phase entry, then count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ro_puf_meas_ctrl.sv
// RO PUF measurement controller: clear, window, settle, compare, respond.
// Optional PUF_MARGIN_EN adds the resp_weak output (|diff| < MARGIN).
module ro_puf_meas_ctrl
  import puf_pkg::*;
#(
  parameter int NUM_RO        = 16,
  parameter int SEL_W         = SEL_W_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int WINDOW_CYCLES = 1024,
  parameter int CLR_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int MARGIN        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chal_valid,
  output logic             chal_ready,
  input  logic [SEL_W-1:0] chal_a,
  input  logic [SEL_W-1:0] chal_b,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic             ro_en,
  output logic             cnt_rst,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_bit,
  output logic             resp_err,
`ifdef PUF_MARGIN_EN
  output logic             resp_weak,
`endif
  output logic             busy
);

  localparam int MAXC = (WINDOW_CYCLES > CLR_CYCLES) ?
    ((WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES) :
    ((CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES);
  localparam int TW = $clog2(MAXC + 1);

  localparam logic [TW-1:0] CLR_LD = TW'(CLR_CYCLES - 1);
  localparam logic [TW-1:0] WIN_LD = TW'(WINDOW_CYCLES - 1);
  localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0] NUM_L = (SEL_W+1)'(NUM_RO);

  state_t          state;
  state_t          state_nx;
  logic            t_load;
  logic [TW-1:0]   t_val;
  logic            t_done;
  logic            accept;
  logic            chal_bad;
  logic [CNT_W:0]  diff;
  logic            gt;
  logic            wrap;
  logic            weak_c;

  puf_window_timer #(
    .TW(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (t_load),
    .load_val(t_val),
    .done    (t_done)
  );

  assign chal_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);

  assign chal_bad = (chal_a == chal_b)
                 || ({1'b0, chal_a} >= NUM_L)
                 || ({1'b0, chal_b} >= NUM_L);

  assign diff = {1'b0, cnt_a} - {1'b0, cnt_b};
  assign gt   = ~diff[CNT_W] & (|diff);
  assign wrap = (&cnt_a) | (&cnt_b);

`ifdef PUF_MARGIN_EN
  localparam logic [CNT_W:0] MARGIN_L = (CNT_W+1)'(MARGIN);
  logic [CNT_W:0] mag;
  assign mag    = diff[CNT_W] ? (~diff + 1'b1) : diff;
  assign weak_c = (mag < MARGIN_L);
`else
  logic unused_margin;
  assign unused_margin = ^MARGIN;
  assign weak_c = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, timer loads and challenge acceptance.
  always_comb begin
    state_nx = state;
    t_load   = 1'b0;
    t_val    = '0;
    accept   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (chal_valid) begin
          accept = 1'b1;
          if (chal_bad) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_CLR;
            t_load   = 1'b1;
            t_val    = CLR_LD;
          end
        end
      end
      S_CLR: begin
        if (t_done) begin
          state_nx = S_RUN;
          t_load   = 1'b1;
          t_val    = WIN_LD;
        end
      end
      S_RUN: begin
        if (t_done) begin
          state_nx = S_SETTLE;
          t_load   = 1'b1;
          t_val    = SET_LD;
        end
      end
      S_SETTLE: begin
        if (t_done) state_nx = S_CMP;
      end
      S_CMP: state_nx = S_DONE;
      S_DONE: begin
        if (resp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Registered datapath outputs, decoded one cycle ahead from state_nx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_a      <= '0;
      sel_b      <= '0;
      ro_en      <= 1'b0;
      cnt_rst    <= 1'b0;
      resp_valid <= 1'b0;
      resp_bit   <= 1'b0;
      resp_err   <= 1'b0;
`ifdef PUF_MARGIN_EN
      resp_weak  <= 1'b0;
`endif
    end else begin
      ro_en      <= (state_nx == S_RUN);
      cnt_rst    <= (state_nx == S_CLR);
      resp_valid <= (state_nx == S_DONE);
      if (accept) begin
        sel_a    <= chal_a;
        sel_b    <= chal_b;
        resp_bit <= 1'b0;
        resp_err <= chal_bad;
`ifdef PUF_MARGIN_EN
        resp_weak <= 1'b0;
`endif
      end
      if (state == S_CMP) begin
        resp_bit <= gt;
        resp_err <= wrap;
`ifdef PUF_MARGIN_EN
        resp_weak <= weak_c;
`endif
      end
    end
  end

`ifndef PUF_MARGIN_EN
  logic unused_weak;
  assign unused_weak = weak_c;
`endif

endmodule

// File: tb/tb_ro_puf_meas_ctrl.sv
// Directed bench for ro_puf_meas_ctrl (default and small-window instances).
// Honours PUF_MARGIN_EN for the resp_weak checks.
module tb_ro_puf_meas_ctrl;

  logic        clk = 0;
  logic        rst = 1;
  logic        chal_valid = 0;
  logic [3:0]  chal_a = 0;
  logic [3:0]  chal_b = 0;
  logic [15:0] cnt_a = 0;
  logic [15:0] cnt_b = 0;
  logic        resp_ready = 0;
  logic        chal_ready, ro_en, cnt_rst;
  logic        resp_valid, resp_bit, resp_err, busy;
  logic [3:0]  sel_a, sel_b;
`ifdef PUF_MARGIN_EN
  logic        resp_weak, w2;
`endif

  logic        c2_valid = 0;
  logic [3:0]  c2_a = 0;
  logic [3:0]  c2_b = 0;
  logic        r2_ready = 0;
  logic        c2_ready, en2, crst2, v2, b2, e2, busy2;
  logic [3:0]  s2a, s2b;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  int clr_cnt = 0;
  int sel_chg = 0;
  logic [3:0] psa = 0;
  logic [3:0] psb = 0;

  always #5 clk = ~clk;

  ro_puf_meas_ctrl dut (
    .clk(clk), .rst(rst),
    .chal_valid(chal_valid), .chal_ready(chal_ready),
    .chal_a(chal_a), .chal_b(chal_b),
    .sel_a(sel_a), .sel_b(sel_b),
    .ro_en(ro_en), .cnt_rst(cnt_rst),
    .cnt_a(cnt_a), .cnt_b(cnt_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_bit(resp_bit), .resp_err(resp_err),
`ifdef PUF_MARGIN_EN
    .resp_weak(resp_weak),
`endif
    .busy(busy)
  );

  ro_puf_meas_ctrl #(
    .NUM_RO(12), .WINDOW_CYCLES(3),
    .CLR_CYCLES(1), .SETTLE_CYCLES(1)
  ) dut12 (
    .clk(clk), .rst(rst),
    .chal_valid(c2_valid), .chal_ready(c2_ready),
    .chal_a(c2_a), .chal_b(c2_b),
    .sel_a(s2a), .sel_b(s2b),
    .ro_en(en2), .cnt_rst(crst2),
    .cnt_a(16'd10), .cnt_b(16'd20),
    .resp_valid(v2), .resp_ready(r2_ready),
    .resp_bit(b2), .resp_err(e2),
`ifdef PUF_MARGIN_EN
    .resp_weak(w2),
`endif
    .busy(busy2)
  );

  always @(posedge clk) begin
    if (ro_en) en_cnt++;
    if (cnt_rst) clr_cnt++;
    if (ro_en && (sel_a != psa || sel_b != psb)) sel_chg++;
    psa = sel_a;
    psb = sel_b;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input logic [3:0] a, input logic [3:0] b,
                     input logic [15:0] ca, input logic [15:0] cb,
                     output int lat);
    @(negedge clk);
    chal_a = a; chal_b = b;
    cnt_a = ca; cnt_b = cb;
    chal_valid = 1;
    @(posedge clk);
    #1 chal_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 3000);
  endtask

  task automatic take();
    @(negedge clk);
    resp_ready = 1;
    @(posedge clk);
    #1 resp_ready = 0;
    @(negedge clk);
    chk("idle_ready", chal_ready, 1);
    chk("idle_valid", resp_valid, 0);
  endtask

  int lat;
  int e0, c0, s0;
  int unstable;
  logic hb, he;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sel", {sel_a, sel_b}, 0);
    chk("rst_en", {ro_en, cnt_rst}, 0);
    chk("rst_resp", {resp_valid, resp_bit, resp_err}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", chal_ready, 1);
    rst = 0;
    repeat (2) @(negedge clk);

    run(3, 7, 500, 480, lat);
    chk("t1_lat", lat, 1032);
    chk("t1_bit", resp_bit, 1);
    chk("t1_err", resp_err, 0);
    chk("t1_sel", {sel_a, sel_b}, {4'd3, 4'd7});
`ifdef PUF_MARGIN_EN
    chk("t1_weak", resp_weak, 0);
`endif
    take();

    run(3, 7, 480, 500, lat);
    chk("t2_lt_bit", resp_bit, 0);
`ifdef PUF_MARGIN_EN
    chk("t2_lt_weak", resp_weak, 0);
`endif
    take();
    run(3, 7, 500, 500, lat);
    chk("t2_eq_bit", resp_bit, 0);
    chk("t2_eq_err", resp_err, 0);
`ifdef PUF_MARGIN_EN
    chk("t2_eq_weak", resp_weak, 1);
`endif
    take();
`ifdef PUF_MARGIN_EN
    run(3, 7, 495, 500, lat);
    chk("t2_near_weak", resp_weak, 1);
    take();
`endif

    e0 = en_cnt;
    run(5, 5, 500, 480, lat);
    chk("t3_lat", lat, 1);
    chk("t3_err", resp_err, 1);
    chk("t3_bit", resp_bit, 0);
    chk("t3_no_en", en_cnt - e0, 0);
`ifdef PUF_MARGIN_EN
    chk("t3_weak", resp_weak, 0);
`endif
    take();

    @(negedge clk);
    c2_a = 13; c2_b = 2; c2_valid = 1;
    @(posedge clk);
    #1 c2_valid = 0;
    @(negedge clk);
    chk("t3b_valid", v2, 1);
    chk("t3b_err", {e2, b2}, 2'b10);
    r2_ready = 1;
    @(posedge clk);
    #1 r2_ready = 0;
    @(negedge clk);
    c2_a = 11; c2_b = 2; c2_valid = 1;
    @(posedge clk);
    #1 c2_valid = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!v2 && lat < 100);
    chk("t3c_lat", lat, 7);
    chk("t3c_resp", {e2, b2}, 2'b00);
    r2_ready = 1;
    @(posedge clk);
    #1 r2_ready = 0;

    run(1, 2, 100, 50, lat);
    hb = resp_bit; he = resp_err;
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (!resp_valid || chal_ready || resp_bit != hb || resp_err != he)
        unstable++;
    end
    chk("t4_hold", unstable, 0);
    chk("t4_bit", {hb, he}, 2'b10);
    take();

    @(negedge clk);
    chal_a = 4; chal_b = 6; chal_valid = 1;
    @(posedge clk);
    #1 chal_valid = 0;
    repeat (300) @(negedge clk);
    chk("t5_en_pre", ro_en, 1);
    #2 rst = 1;
    #1;
    chk("t5_en_rst", {ro_en, cnt_rst}, 0);
    chk("t5_valid", resp_valid, 0);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(2, 9, 300, 310, lat);
    chk("t5_lat", lat, 1032);
    chk("t5_resp", {resp_bit, resp_err}, 2'b00);
    take();

    e0 = en_cnt; c0 = clr_cnt; s0 = sel_chg;
    run(8, 1, 16'hFFFF, 16'd0, lat);
    chk("t6_err", resp_err, 1);
    chk("t6_bit", resp_bit, 1);
    chk("t6_en_len", en_cnt - e0, 1024);
    chk("t6_clr_len", clr_cnt - c0, 2);
    chk("t6_sel_chg", sel_chg - s0, 0);
    chk("t6_sel", {sel_a, sel_b}, {4'd8, 4'd1});
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
